// File: rtl/kf_iter_sequencer.sv
// Purpose : sequences Kalman-filter iterations: INIT dwell, wait for a measurement,
//           walk NUM_STAGES one-hot stage enables, count iterations, detect end of data.
// Latency : all outputs are Moore-decoded from registered state; stage advance 1 cycle after stage_done[k].
// Backpressure: none; a stage holds its enable until stage_done[k] or the watchdog fires.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, abort        begin a run / cancel the run (abort wins over everything but rst)
//   meas_valid          a measurement is ready, launches one iteration from WAIT_MEAS
//   all_meas_read       source exhausted; must stay high END_STABLE_CYCLES cycles to arm end
//   stage_done          per-stage completion, only the bit of the active stage is used
//   init_en, stage_en, cur_stage, busy, iter_cnt, iter_done, finish, timeout_err  status/enables
module kf_iter_sequencer #(
    parameter int NUM_STAGES        = 4,
    parameter int INIT_DELAY_CYCLES = 10,
    parameter int END_STABLE_CYCLES = 50,
    parameter int MAX_ITER          = 0,
    parameter int ITER_W            = 16,
    parameter int STAGE_TIMEOUT     = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  meas_valid,
    input  logic                  all_meas_read,
    input  logic [NUM_STAGES-1:0] stage_done,
    output logic                  init_en,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [2:0]            cur_stage,
    output logic                  busy,
    output logic [ITER_W-1:0]     iter_cnt,
    output logic                  iter_done,
    output logic                  finish,
    output logic                  timeout_err
);

    // A zero INIT delay still spends one cycle in INIT.
    localparam int INIT_LAST = (INIT_DELAY_CYCLES > 1) ? INIT_DELAY_CYCLES - 1 : 0;
    localparam int INIT_W    = (INIT_LAST > 0) ? $clog2(INIT_LAST + 1) : 1;
    localparam int END_LAST  = (END_STABLE_CYCLES > 1) ? END_STABLE_CYCLES - 1 : 0;
    localparam int END_W     = (END_LAST > 0) ? $clog2(END_LAST + 1) : 1;
    localparam int WD_LAST   = (STAGE_TIMEOUT > 1) ? STAGE_TIMEOUT - 1 : 0;
    localparam int WD_W      = (WD_LAST > 0) ? $clog2(WD_LAST + 1) : 1;
    localparam bit WD_EN     = (STAGE_TIMEOUT != 0);
    localparam bit MAX_EN    = (MAX_ITER != 0);
    localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INIT,
        S_WAIT,
        S_RUN,
        S_ITER,
        S_DONE,
        S_ERR
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [INIT_W-1:0]  init_cnt;
    logic [END_W-1:0]   end_cnt;
    logic               end_armed;
    logic [WD_W-1:0]    wdog_cnt;
    logic [2:0]         stage_idx;
    logic [ITER_W-1:0]  iter_inc;
    logic               done_cur;
    logic               go;
    logic               kill;

    // Only the active stage's completion bit matters.
    always_comb begin
        done_cur = 1'b0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (stage_idx == 3'(i) && stage_done[i]) begin
                done_cur = 1'b1;
            end
        end
    end

    assign iter_inc = (&iter_cnt) ? iter_cnt : iter_cnt + ITER_W'(1);
    assign go       = (state == S_IDLE || state == S_ERR) && start && !abort;
    assign kill     = abort && (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_ERR: begin
                if (start) begin
                    state_nxt = S_INIT;
                end
            end
            S_INIT: begin
                if (init_cnt == INIT_W'(INIT_LAST)) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                // End-of-data is only honoured here so a running iteration always completes.
                if (end_armed) begin
                    state_nxt = S_DONE;
                end else if (meas_valid) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // A completion in the watchdog's last cycle still advances.
                if (done_cur) begin
                    if (stage_idx == LAST_STAGE) begin
                        state_nxt = S_ITER;
                    end
                end else if (WD_EN && wdog_cnt == WD_W'(WD_LAST)) begin
                    state_nxt = S_ERR;
                end
            end
            S_ITER: begin
                if (MAX_EN && iter_inc == ITER_W'(MAX_ITER)) begin
                    state_nxt = S_DONE;
                end else begin
                    state_nxt = S_WAIT;
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = S_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            init_cnt  <= '0;
            wdog_cnt  <= '0;
            stage_idx <= '0;
            iter_cnt  <= '0;
            end_cnt   <= '0;
            end_armed <= 1'b0;
        end else begin
            if (state == S_INIT && state_nxt == S_INIT) begin
                init_cnt <= init_cnt + INIT_W'(1);
            end else begin
                init_cnt <= '0;
            end

            if (state_nxt != S_RUN) begin
                stage_idx <= '0;
            end else if (state == S_RUN && done_cur) begin
                stage_idx <= stage_idx + 3'd1;
            end

            // Restarts on every stage entry; held at zero when the watchdog is disabled.
            if (WD_EN && state == S_RUN && state_nxt == S_RUN && !done_cur) begin
                wdog_cnt <= wdog_cnt + WD_W'(1);
            end else begin
                wdog_cnt <= '0;
            end

            if (go || kill) begin
                iter_cnt <= '0;
            end else if (state == S_ITER) begin
                iter_cnt <= iter_inc;
            end

            if (go || abort) begin
                end_cnt   <= '0;
                end_armed <= 1'b0;
            end else if (state != S_IDLE && !end_armed) begin
                if (all_meas_read) begin
                    if (end_cnt == END_W'(END_LAST)) begin
                        end_armed <= 1'b1;
                    end else begin
                        end_cnt <= end_cnt + END_W'(1);
                    end
                end else begin
                    end_cnt <= '0;
                end
            end
        end
    end

    always_comb begin
        stage_en = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            stage_en[i] = (state == S_RUN) && (stage_idx == 3'(i));
        end
    end

    assign init_en     = (state == S_INIT);
    assign cur_stage   = (state == S_RUN) ? stage_idx : 3'd0;
    assign busy        = (state != S_IDLE);
    assign iter_done   = (state == S_ITER);
    assign finish      = (state == S_DONE);
    assign timeout_err = (state == S_ERR);

endmodule

// File: tb/tb_kf_iter_sequencer.sv
// Purpose : directed checks of kf_iter_sequencer with defaults plus a MAX_ITER=3 instance.
// Latency : inputs driven 1 ns after posedge, outputs sampled at the same point.
// Backpressure: n/a.
module tb_kf_iter_sequencer;

    logic        clk;
    logic        rst;
    logic        start;
    logic        start_m;
    logic        abort;
    logic        meas_valid;
    logic        all_meas_read;
    logic [3:0]  stage_done;

    logic        init_en, busy, iter_done, finish, timeout_err;
    logic [3:0]  stage_en;
    logic [2:0]  cur_stage;
    logic [15:0] iter_cnt;

    logic        init_en_m, busy_m, iter_done_m, finish_m, timeout_err_m;
    logic [3:0]  stage_en_m;
    logic [2:0]  cur_stage_m;
    logic [15:0] iter_cnt_m;

    int n_tests = 0;
    int n_fail  = 0;

    kf_iter_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .meas_valid(meas_valid), .all_meas_read(all_meas_read), .stage_done(stage_done),
        .init_en(init_en), .stage_en(stage_en), .cur_stage(cur_stage), .busy(busy),
        .iter_cnt(iter_cnt), .iter_done(iter_done), .finish(finish), .timeout_err(timeout_err)
    );

    kf_iter_sequencer #(.MAX_ITER(3)) dut_m (
        .clk(clk), .rst(rst), .start(start_m), .abort(abort),
        .meas_valid(meas_valid), .all_meas_read(all_meas_read), .stage_done(stage_done),
        .init_en(init_en_m), .stage_en(stage_en_m), .cur_stage(cur_stage_m), .busy(busy_m),
        .iter_cnt(iter_cnt_m), .iter_done(iter_done_m), .finish(finish_m), .timeout_err(timeout_err_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: observed no end of run, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        rst = 1'b1; start = 1'b0; start_m = 1'b0; abort = 1'b0;
        meas_valid = 1'b0; all_meas_read = 1'b0; stage_done = 4'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", 32'(busy), 0);
        chk("rst_stage_en", 32'(stage_en), 0);
        chk("rst_iter_cnt", 32'(iter_cnt), 0);
        chk("rst_init_en", 32'(init_en), 0);
        chk("rst_timeout", 32'(timeout_err), 0);
        chk("rst_finish", 32'(finish), 0);

        // Nominal: INIT cycles 1..10, meas in cycle 12, stages done 3 cycles after enable
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            chk("nom_init_en", 32'(init_en), 1);
            tick();
        end
        chk("nom_init_off", 32'(init_en), 0);
        chk("nom_wait_busy", 32'(busy), 1);
        tick();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("nom_stage_en", 32'(stage_en), 32'(1 << k));
            chk("nom_cur_stage", 32'(cur_stage), 32'(k));
            repeat (3) tick();
            stage_done = 4'(1 << k);
            tick();
            stage_done = 4'b0;
        end
        chk("nom_iter_done", 32'(iter_done), 1);
        tick();
        chk("nom_iter_done_once", 32'(iter_done), 0);
        chk("nom_iter_cnt", 32'(iter_cnt), 1);
        chk("nom_no_finish", 32'(finish), 0);

        // End: all_meas_read high 50 cycles during RUN, iteration still completes
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (i % 15 == 0) chk("end_stage_en", 32'(stage_en), 32'(1 << (i / 15)));
            all_meas_read = (i < 50);
            stage_done = (i % 15 == 14) ? 4'(1 << (i / 15)) : 4'b0;
            tick();
        end
        all_meas_read = 1'b0;
        stage_done = 4'b0;
        chk("end_iter_done", 32'(iter_done), 1);
        tick();
        chk("end_wait_no_finish", 32'(finish), 0);
        chk("end_iter_cnt", 32'(iter_cnt), 2);
        tick();
        chk("end_finish", 32'(finish), 1);
        tick();
        chk("end_finish_pulse", 32'(finish), 0);
        chk("end_idle", 32'(busy), 0);
        chk("end_iter_cnt_held", 32'(iter_cnt), 2);

        // New run clears iter_cnt
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("restart_iter_cnt", 32'(iter_cnt), 0);
        chk("restart_init_en", 32'(init_en), 1);
        repeat (10) tick();
        chk("restart_wait", 32'(init_en), 0);

        // 49 cycles high then 1 low must not arm
        all_meas_read = 1'b1;
        repeat (49) tick();
        all_meas_read = 1'b0;
        tick();
        repeat (3) tick();
        chk("end49_busy", 32'(busy), 1);
        chk("end49_no_finish", 32'(finish), 0);

        // 50 cycles high arms; meas_valid together with end_armed -> DONE
        all_meas_read = 1'b1;
        repeat (50) tick();
        all_meas_read = 1'b0;
        chk("end50_still_wait", 32'(busy), 1);
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        chk("prio_done_finish", 32'(finish), 1);
        chk("prio_done_stage_en", 32'(stage_en), 0);
        tick();
        chk("prio_done_idle", 32'(busy), 0);

        // Timeout in stage 2; foreign stage_done bits ignored in stage 1
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b1101;
        tick();
        tick();
        chk("ignore_other_bits", 32'(stage_en), 32'h2);
        stage_done = 4'b0010;
        tick();
        stage_done = 4'b0;
        chk("to_stage2", 32'(stage_en), 32'h4);
        repeat (1023) tick();
        chk("to_pre_stage_en", 32'(stage_en), 32'h4);
        chk("to_pre_err", 32'(timeout_err), 0);
        tick();
        chk("to_err", 32'(timeout_err), 1);
        chk("to_err_stage_en", 32'(stage_en), 0);
        chk("to_err_busy", 32'(busy), 1);
        repeat (3) tick();
        chk("to_err_hold", 32'(timeout_err), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("to_clear", 32'(timeout_err), 0);
        chk("to_init", 32'(init_en), 1);

        // stage_done at watchdog cycle 1023 advances
        repeat (10) tick();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        repeat (1023) tick();
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0;
        chk("wd_edge_adv", 32'(stage_en), 32'h2);
        chk("wd_edge_no_err", 32'(timeout_err), 0);
        for (int k = 1; k < 4; k++) begin
            stage_done = 4'(1 << k);
            tick();
        end
        stage_done = 4'b0;
        chk("wd_iter_done", 32'(iter_done), 1);
        tick();
        chk("wd_iter_cnt", 32'(iter_cnt), 1);

        // rst mid-RUN with other inputs active
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        stage_done = 4'b0001;
        tick();
        chk("rstrun_stage1", 32'(stage_en), 32'h2);
        rst = 1'b1; start = 1'b1; meas_valid = 1'b1; stage_done = 4'b0010;
        tick();
        rst = 1'b0; start = 1'b0; meas_valid = 1'b0; stage_done = 4'b0;
        chk("rstrun_busy", 32'(busy), 0);
        chk("rstrun_stage_en", 32'(stage_en), 0);
        chk("rstrun_iter_cnt", 32'(iter_cnt), 0);
        chk("rstrun_iter_done", 32'(iter_done), 0);
        chk("rstrun_finish", 32'(finish), 0);
        tick();
        chk("rstrun_stay_idle", 32'(busy), 0);

        // Abort with start in RUN stage 1 after one completed iteration
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (10) tick();
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            stage_done = 4'(1 << k);
            tick();
        end
        stage_done = 4'b0;
        tick();
        chk("abort_pre_iter_cnt", 32'(iter_cnt), 1);
        meas_valid = 1'b1;
        tick();
        meas_valid = 1'b0;
        stage_done = 4'b0001;
        tick();
        stage_done = 4'b0;
        chk("abort_pre_stage1", 32'(stage_en), 32'h2);
        abort = 1'b1; start = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_stage_en", 32'(stage_en), 0);
        chk("abort_finish", 32'(finish), 0);
        chk("abort_iter_cnt", 32'(iter_cnt), 0);
        tick();
        chk("abort_no_finish", 32'(finish), 0);
        chk("abort_stay_idle", 32'(busy), 0);

        // MAX_ITER=3, continuous meas_valid, every stage done immediately
        start_m = 1'b1;
        tick();
        start_m = 1'b0;
        chk("max_init_en", 32'(init_en_m), 1);
        repeat (10) tick();
        meas_valid = 1'b1;
        stage_done = 4'hf;
        for (int c = 11; c <= 28; c++) begin
            chk("max_iter_done", 32'(iter_done_m), 32'(c == 16 || c == 22 || c == 28));
            if (c == 12) chk("max_stage0", 32'(stage_en_m), 32'h1);
            if (c == 14) chk("max_cur_stage2", 32'(cur_stage_m), 2);
            if (c == 17) chk("max_cnt1", 32'(iter_cnt_m), 1);
            if (c == 23) chk("max_cnt2", 32'(iter_cnt_m), 2);
            tick();
        end
        chk("max_finish", 32'(finish_m), 1);
        chk("max_cnt3", 32'(iter_cnt_m), 3);
        meas_valid = 1'b0;
        stage_done = 4'b0;
        tick();
        chk("max_idle", 32'(busy_m), 0);
        chk("max_cnt_held", 32'(iter_cnt_m), 3);
        chk("max_no_timeout", 32'(timeout_err_m), 0);
        chk("max_dflt_idle", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
